// File: rtl/digit_serial_adder.sv
// ----------------------------------------------------------------------------
// digit_serial_adder
//
// Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit
// first. A chain of DIGIT full-adder cells handles one digit per cycle, and a
// single registered carry links consecutive digits. A result takes
// N = WIDTH/DIGIT compute cycles.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present
//   in_ready   block can accept operands (IDLE only)
//   a, b       operands
//   cin        carry-in for add, borrow-in for subtract
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (for subtract, 1 means no borrow)
//   ovf        two's-complement signed overflow
//   busy       high while in RUN or DONE
// ----------------------------------------------------------------------------
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   // Reject parameter sets that cannot be split into whole digits.
   generate
      if (WIDTH < 1 || DIGIT < 1) begin : g_bad_size
         $error("digit_serial_adder: WIDTH and DIGIT must be at least 1");
      end else if ((WIDTH % DIGIT) != 0) begin : g_bad_split
         $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic [CW-1:0]      r_cnt;
   logic               r_cout;
   logic               r_ovf;

   logic [DIGIT-1:0]       w_dsum;
   logic                   w_dcout;
   logic                   w_cin_msb;
   logic [WIDTH+DIGIT-1:0] w_sum_cat;
   logic [WIDTH-1:0]       w_sum_shift;
   logic                   w_last;
   logic                   w_accept;
   logic                   w_handshake;

   // One full-adder cell: returns {carry_out, sum_bit}.
   function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
      fa = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
   endfunction

   assign w_last      = (r_cnt == LAST_CNT);
   assign w_accept    = in_valid && (r_state == S_IDLE);
   assign w_handshake = out_ready && (r_state == S_DONE);

   // New digit bits enter at the top, so after N digits the register is LSB-aligned.
   assign w_sum_cat   = {w_dsum, r_sum};
   assign w_sum_shift = w_sum_cat[WIDTH+DIGIT-1:DIGIT];

   // Ripple the registered carry through DIGIT full-adder cells on the low operand bits.
   always_comb begin
      logic v_c;
      v_c       = r_carry;
      w_dsum    = '0;
      w_cin_msb = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         // The value left after the last iteration is the carry into the digit MSB.
         w_cin_msb = v_c;
         {v_c, w_dsum[i]} = fa(r_a[i], r_b[i], v_c);
      end
      w_dcout = v_c;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            if (w_handshake) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM outputs, decoded only from the state register.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
         end
         S_RUN: begin
            busy = 1'b1;
         end
         S_DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            in_ready = 1'b1;
         end
      endcase
   end

   // Operand capture, digit-serial compute, and result holding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  // Subtraction becomes a + ~b + ~borrow.
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_carry <= cin ^ sub;
                  r_cnt   <= '0;
               end
            end
            S_RUN: begin
               r_a     <= r_a >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_sum   <= w_sum_shift;
               r_carry <= w_dcout;
               if (w_last) begin
                  r_cnt  <= r_cnt;
                  r_cout <= w_dcout;
                  r_ovf  <= w_cin_msb ^ w_dcout;
               end else begin
                  r_cnt  <= r_cnt + CW'(1);
               end
            end
            S_DONE: begin
               r_sum <= r_sum;
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule
